// File: rtl/reg_wr_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_wr_ctrl : debounced push-button write front end for a small register file
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_wr_ctrl #(
  parameter int DW     = 4,
  parameter int AW     = 2,
  parameter int DB_CNT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic          mode,
  input  logic [AW-1:0] sw_addr,
  input  logic [DW-1:0] sw_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] auto_ptr,
  output logic          busy
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRESS_DB = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;
  localparam logic [1:0] S_REL_DB   = 2'd3;

  logic          sync1;
  logic          btn_s;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          capture;
  logic          wr_en_nx;
  logic          busy_nx;
  logic          auto_mode;

  // State register, debounce counter and button synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (btn_s) begin
          state_nx = S_PRESS_DB;
          cnt_nx   = '0;
        end
      end
      S_PRESS_DB: begin
        if (!btn_s) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = S_WRITE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_WRITE: begin
        state_nx = S_REL_DB;
        cnt_nx   = '0;
      end
      S_REL_DB: begin
        // Any high sample restarts the release window
        if (btn_s) begin
          cnt_nx = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    capture  = (state == S_PRESS_DB) && (state_nx == S_WRITE);
    wr_en_nx = (state_nx == S_WRITE);
    busy_nx  = (state_nx != S_IDLE);
  end

  // Registered outputs; mode is latched at capture so the pointer step follows the write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      auto_ptr  <= '0;
      auto_mode <= 1'b0;
    end else begin
      wr_en <= wr_en_nx;
      busy  <= busy_nx;
      if (capture) begin
        wr_data   <= sw_data;
        wr_addr   <= mode ? auto_ptr : sw_addr;
        auto_mode <= mode;
      end
      if ((state == S_WRITE) && auto_mode) begin
        auto_ptr <= auto_ptr + AW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_wr_ctrl : directed self-checking bench for reg_wr_ctrl (DB_CNT = 4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       mode;
  logic [1:0] sw_addr;
  logic [3:0] sw_data;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] auto_ptr;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int base;

  reg_wr_ctrl #(.DW(4), .AW(2), .DB_CNT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .mode     (mode),
    .sw_addr  (sw_addr),
    .sw_data  (sw_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .auto_ptr (auto_ptr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en) wr_count++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; mode = 1'b0; sw_addr = 2'd0; sw_data = 4'd0;
    step(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_auto_ptr", auto_ptr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step(2);

    // Clean direct write: strobe lands 7 edges after btn rises
    mode = 1'b0; sw_addr = 2'd2; sw_data = 4'hA; btn = 1'b1;
    base = wr_count;
    step(6);
    check("direct_pre_wr_en", wr_en, 0);
    check("direct_pre_busy", busy, 1);
    step(1);
    check("direct_wr_en", wr_en, 1);
    check("direct_wr_addr", wr_addr, 2);
    check("direct_wr_data", wr_data, 4'hA);
    check("direct_auto_ptr", auto_ptr, 0);
    step(1);
    check("direct_strobe_1cyc", wr_en, 0);
    step(12);
    check("direct_held_one_write", wr_count - base, 1);
    check("direct_hold_addr", wr_addr, 2);
    btn = 1'b0;
    step(5);
    check("direct_rel_busy", busy, 1);
    step(1);
    check("direct_rel_idle", busy, 0);

    // Bounce reject
    base = wr_count;
    sw_data = 4'h7;
    for (int i = 0; i < 15; i++) begin
      btn = ~btn;
      step(2);
    end
    btn = 1'b0;
    step(8);
    check("bounce_no_write", wr_count - base, 0);
    check("bounce_idle", busy, 0);
    check("bounce_data_kept", wr_data, 4'hA);

    // Auto mode with pointer wrap
    mode = 1'b1; sw_addr = 2'd3;
    for (int i = 1; i <= 5; i++) begin
      sw_data = 4'(i);
      btn = 1'b1;
      step(7);
      check($sformatf("auto%0d_wr_en", i), wr_en, 1);
      check($sformatf("auto%0d_addr", i), wr_addr, (i - 1) % 4);
      check($sformatf("auto%0d_data", i), wr_data, i);
      btn = 1'b0;
      step(8);
    end
    check("auto_ptr_end", auto_ptr, 1);

    // Release glitch: low 2, high 1, low
    mode = 1'b0; sw_addr = 2'd1; sw_data = 4'h3;
    btn = 1'b1;
    step(7);
    check("glitch_write", wr_en, 1);
    step(2);
    base = wr_count;
    btn = 1'b0;
    step(2);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    step(5);
    check("glitch_busy_late", busy, 1);
    step(1);
    check("glitch_idle", busy, 0);
    check("glitch_no_rewrite", wr_count - base, 0);
    check("glitch_ptr_kept", auto_ptr, 1);

    // Reset during PRESS_DB
    base = wr_count;
    sw_addr = 2'd2; sw_data = 4'h9;
    btn = 1'b1;
    step(4);
    check("rstpress_busy_before", busy, 1);
    rst = 1'b1; btn = 1'b0;
    step(1);
    check("rstpress_busy", busy, 0);
    check("rstpress_auto_ptr", auto_ptr, 0);
    check("rstpress_wr_addr", wr_addr, 0);
    check("rstpress_wr_data", wr_data, 0);
    rst = 1'b0;
    step(10);
    check("rstpress_no_write", wr_count - base, 0);

    // Reset during RELEASE_DB
    sw_addr = 2'd3; sw_data = 4'hC;
    btn = 1'b1;
    step(7);
    check("rstrel_write", wr_en, 1);
    step(2);
    rst = 1'b1;
    step(1);
    check("rstrel_wr_en", wr_en, 0);
    check("rstrel_busy", busy, 0);
    check("rstrel_wr_addr", wr_addr, 0);
    check("rstrel_wr_data", wr_data, 0);
    rst = 1'b0; btn = 1'b0;
    step(4);

    // Fresh press after reset
    base = wr_count;
    sw_addr = 2'd1; sw_data = 4'h5;
    btn = 1'b1;
    step(7);
    check("fresh_wr_en", wr_en, 1);
    check("fresh_wr_addr", wr_addr, 1);
    check("fresh_wr_data", wr_data, 4'h5);
    btn = 1'b0;
    step(8);
    check("fresh_one_write", wr_count - base, 1);
    check("fresh_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
